// File: rtl/reg_cmd_ctrl.sv
// Byte-command register controller: decodes 0xAA (write) / 0xBB (read) command streams
// into single-cycle register-file strobes and returns read data as one response byte.
module reg_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int RD_TIMEOUT = 15,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wr_en,
  output logic [WIDTH-1:0]  rf_wr_data,
  output logic              rf_rd_en,
  input  logic [WIDTH-1:0]  rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [WIDTH-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              cmd_err,
  output logic              busy
);

  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam int CMP_W = (WIDTH > 32) ? WIDTH : 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] rd_buf;
  logic [WIDTH-1:0] tx_hold;
  logic             addr_ok;

  // Compare in a wide domain so a DEPTH that exceeds the byte range cannot wrap.
  assign addr_ok = (CMP_W'(rx_data) < CMP_W'(DEPTH));

  assign busy = (state != IDLE);

  // The response byte is offered in the very first cycle the transmitter is free;
  // tx_data shows the captured read data only during that strobe and otherwise
  // holds the last byte sent.
  assign tx_valid = (state == TX_SEND) && !tx_busy;
  assign tx_data  = tx_valid ? rd_buf : tx_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rd_buf     <= '0;
      tx_hold    <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first make every strobe a one-cycle pulse
      // unless a branch below re-asserts it; all branches read pre-edge state.
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      cmd_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WR)      state <= WR_ADDR;
            else if (rx_data == CMD_RD) state <= RD_ADDR;
            else                        cmd_err <= 1'b1;
          end
        end

        WR_ADDR: begin
          if (rx_valid) begin
            if (addr_ok) begin
              rf_addr <= rx_data[ADDR_W-1:0];
              state   <= WR_DATA;
            end else begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= WR_EXEC;
          end
        end

        // rf_wr_en is high for this whole state; bytes arriving now are dropped.
        WR_EXEC: state <= IDLE;

        RD_ADDR: begin
          if (rx_valid) begin
            if (addr_ok) begin
              rf_addr  <= rx_data[ADDR_W-1:0];
              rf_rd_en <= 1'b1;
              state    <= RD_EXEC;
            end else begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        // A read-valid seen alongside the strobe itself cannot be the answer to it.
        RD_EXEC: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (rf_rd_valid) begin
            rd_buf <= rf_rd_data;
            state  <= TX_SEND;
          end else if (wait_cnt == WAIT_LAST) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        TX_SEND: begin
          if (!tx_busy) begin
            tx_hold <= rd_buf;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/byte width.
REQ-002 SHALL have parameter DEPTH, default 16, register count; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter RD_TIMEOUT, default 15, max cycles waiting for read data.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 RX_DATA  input  WIDTH  received command/operand byte.
REQ-007 RX_VALID  input  1  one-cycle strobe, RX_DATA valid.
REQ-008 RF_ADDR  output  ADDR_W  register-file address.
REQ-009 RF_WR_EN  output  1  register-file write strobe.
REQ-010 RF_WR_DATA  output  WIDTH  register-file write data.
REQ-011 RF_RD_EN  output  1  register-file read strobe.
REQ-012 RF_RD_DATA  input  WIDTH  register-file read data.
REQ-013 RF_RD_VALID  input  1  register-file read data valid.
REQ-014 TX_DATA  output  WIDTH  response byte.
REQ-015 TX_VALID  output  1  one-cycle strobe, TX_DATA valid.
REQ-016 TX_BUSY  input  1  transmitter cannot accept a byte.
REQ-017 CMD_ERR  output  1  one-cycle error pulse.
REQ-018 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
REQ-020 IDLE: RX_VALID with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> stay IDLE, CMD_ERR pulse next cycle.
REQ-021 WR_ADDR/RD_ADDR: on RX_VALID, byte < DEPTH latched as address, advance to WR_DATA/RD_EXEC; byte >= DEPTH -> IDLE, CMD_ERR pulse, no register access.
REQ-022 WR_DATA: on RX_VALID latch byte to RF_WR_DATA, go WR_EXEC.
REQ-023 WR_EXEC: RF_WR_EN high exactly one cycle with stable RF_ADDR/RF_WR_DATA, then IDLE; no TX response for writes.
REQ-024 RD_EXEC: RF_RD_EN high exactly one cycle, then RD_WAIT.
REQ-025 RD_WAIT: on RF_RD_VALID latch RF_RD_DATA, go TX_SEND; RF_RD_VALID sampled also in the RD_EXEC cycle is ignored.
REQ-026 RD_WAIT: wait counter reaching RD_TIMEOUT cycles without RF_RD_VALID -> IDLE, CMD_ERR pulse, no TX.
REQ-027 TX_SEND: while TX_BUSY high hold; first cycle TX_BUSY low drive TX_VALID one cycle with latched data, then IDLE.
REQ-028 RF_WR_EN and RF_RD_EN SHALL never be high in the same cycle.
REQ-029 RX_VALID in WR_EXEC, RD_EXEC, RD_WAIT, TX_SEND SHALL be dropped without error and without state change.
REQ-030 RF_ADDR, RF_WR_DATA, TX_DATA SHALL hold last value outside their strobe cycles.
REQ-031 Command latency: RF_WR_EN asserts 1 cycle after data-byte strobe; RF_RD_EN asserts 1 cycle after address-byte strobe.
REQ-032 Back-to-back commands: a new command byte accepted in IDLE the cycle after returning to IDLE.

Reset
REQ-033 RST high SHALL force IDLE and all outputs to 0 (RF_ADDR, RF_WR_DATA, TX_DATA = 0; strobes, CMD_ERR, BUSY = 0) and clear counter and latches asynchronously.
REQ-034 RST mid-command SHALL abort the command with no strobe issued; next byte after release decoded as a fresh command.

Verification
REQ-035 Write: RX 0xAA, 0x05, 0x3C -> one-cycle RF_WR_EN, RF_ADDR=5, RF_WR_DATA=0x3C; no TX_VALID.
REQ-036 Read: RX 0xBB, 0x01; model returns 0x77 with RF_RD_VALID 1 cycle after RF_RD_EN -> TX_VALID once, TX_DATA=0x77.
REQ-037 Errors: RX 0x12 -> CMD_ERR pulse, no strobes; RX 0xAA, 0x10 (DEPTH=16) -> CMD_ERR, no RF_WR_EN.
REQ-038 Timeout: RX 0xBB, 0x02, RF_RD_VALID never -> CMD_ERR after 15 wait cycles, no TX_VALID, BUSY low after.
REQ-039 Backpressure: read of 0x03 returning 0x10 with TX_BUSY high 20 cycles -> TX_VALID only in first cycle TX_BUSY low; RX bytes during wait dropped.
REQ-040 Reset: assert RST after 0xAA, 0x04 -> no RF_WR_EN; after release RX 0xBB, 0x04 executes as a read.
